// File: rtl/operacao_mult_pkg.sv
// Shared definitions for the operation stage: state encoding and default operand width.
// The control FSM and the display logic use the same 2-bit state style.
package operacao_mult_pkg;

  localparam int WIDTH_DEF = 8;

  typedef logic [1:0] estado_t;

  localparam estado_t OCIOSO = 2'd0;
  localparam estado_t CALC   = 2'd1;
  localparam estado_t FIM    = 2'd2;

endpackage

// File: rtl/operacao_mult_if.sv
// Handshake and data bundle between the control FSM (master) and the multiplier (slave).
interface operacao_mult_if #(
  parameter int WIDTH = 8
);

  logic                 HabOp;
  logic [WIDTH-1:0]     dadoA;
  logic [WIDTH-1:0]     dadoB;
  logic                 fimOp;
  logic [2*WIDTH-1:0]   resultado;
  logic                 ocupado;
  logic [1:0]           estado;

  modport master (
    output HabOp, dadoA, dadoB,
    input  fimOp, resultado, ocupado, estado
  );

  modport slave (
    input  HabOp, dadoA, dadoB,
    output fimOp, resultado, ocupado, estado
  );

endinterface

// File: rtl/operacao_mult_datapath.sv
// Shift-and-add datapath: accumulator, shifting operands and iteration counter.
// 'sum' is the accumulator value after the current iteration, so the FSM can capture it on the last step.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] sum,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] addend_s;

  // Partial product for this iteration and the last-iteration flag
  always_comb begin
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {(2*WIDTH){1'b0}};
    end
    sum  = acc_r + addend_s;
    last = (cnt_r == CW'(WIDTH - 1));
  end

  // Operand capture on load, one shift-and-add iteration per step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (load) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      cnt_r    <= {CW{1'b0}};
    end else if (step) begin
      acc_r    <= sum;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + CW'(1);
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
    end
  end

endmodule

// File: rtl/operacao_mult.sv
// Operation stage: sequential unsigned multiplier started by HabOp, reporting fimOp when done.
// Latency is a constant WIDTH cycles; dropping HabOp during CALC aborts without touching resultado.
module operacao_mult
  import operacao_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic           clk,
  input logic           rst,
  operacao_mult_if.slave bus
);

  estado_t            state_r;
  estado_t            next_s;
  logic               load_s;
  logic               step_s;
  logic               last_s;
  logic [2*WIDTH-1:0] sum_s;
  logic [2*WIDTH-1:0] resultado_r;
  logic               fim_r;
  logic               ocupado_r;

  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .step (step_s),
    .a    (bus.dadoA),
    .b    (bus.dadoB),
    .sum  (sum_s),
    .last (last_s)
  );

  // Next-state and datapath control decode
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_r)
      OCIOSO: begin
        if (bus.HabOp) begin
          next_s = CALC;
          load_s = 1'b1;
        end else begin
          next_s = OCIOSO;
        end
      end
      CALC: begin
        if (!bus.HabOp) begin
          next_s = OCIOSO;
        end else begin
          step_s = 1'b1;
          if (last_s) begin
            next_s = FIM;
          end else begin
            next_s = CALC;
          end
        end
      end
      FIM: begin
        if (!bus.HabOp) begin
          next_s = OCIOSO;
        end else begin
          next_s = FIM;
        end
      end
      default: begin
        next_s = OCIOSO;
      end
    endcase
  end

  // State register and registered status/result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= OCIOSO;
      fim_r       <= 1'b0;
      ocupado_r   <= 1'b0;
      resultado_r <= {(2*WIDTH){1'b0}};
    end else begin
      state_r   <= next_s;
      fim_r     <= (next_s == FIM);
      ocupado_r <= (next_s == CALC);
      if (step_s && last_s) begin
        resultado_r <= sum_s;
      end else begin
        resultado_r <= resultado_r;
      end
    end
  end

  assign bus.fimOp     = fim_r;
  assign bus.ocupado   = ocupado_r;
  assign bus.resultado = resultado_r;
  assign bus.estado    = state_r;

endmodule

// File: tb/tb_operacao_mult.sv
// Self-checking bench for operacao_mult: expected products come from plain a*b arithmetic,
// expected timing from the documented WIDTH-cycle latency and handshake rules.
module tb_operacao_mult;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [2*W-1:0] last_prod;

  operacao_mult_if #(.WIDTH(W)) bus ();

  operacao_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full operation as the control FSM performs it; operands are scrambled after the start edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input string tag);
    logic [2*W-1:0] expv;
    logic [4:0]     exp_st;
    logic [4:0]     got_st;
    expv = (2*W)'(a) * (2*W)'(b);
    bus.dadoA = a;
    bus.dadoB = b;
    bus.HabOp = 1'b1;
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      got_st = {bus.estado, bus.ocupado, bus.fimOp, 1'b0};
      if (i < W) exp_st = {2'd1, 1'b1, 1'b0, 1'b0};
      else       exp_st = {2'd2, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (got_st !== exp_st) begin
        n_err++;
        $display("FAIL %s status cycle %0d: got estado/ocupado/fimOp %b expected %b", tag, i, got_st[4:1], exp_st[4:1]);
      end
      n_cmp++;
      if (bus.resultado !== ((i < W) ? last_prod : expv)) begin
        n_err++;
        $display("FAIL %s resultado cycle %0d: got %0d expected %0d", tag, i, bus.resultado,
                 (i < W) ? last_prod : expv);
      end
      bus.dadoA = W'($urandom);
      bus.dadoB = W'($urandom);
    end
    last_prod = expv;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.fimOp !== 1'b1 || bus.resultado !== expv) begin
        n_err++;
        $display("FAIL %s hold %0d: got fimOp %b res %0d expected 1 %0d", tag, h, bus.fimOp, bus.resultado, expv);
      end
    end
    bus.HabOp = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.fimOp !== 1'b0 || bus.estado !== 2'd0 || bus.ocupado !== 1'b0 || bus.resultado !== expv) begin
      n_err++;
      $display("FAIL %s release: got fimOp %b estado %0d ocupado %b res %0d expected 0 0 0 %0d",
               tag, bus.fimOp, bus.estado, bus.ocupado, bus.resultado, expv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.HabOp = 1'b0;
    bus.dadoA = 8'd0;
    bus.dadoB = 8'd0;
    last_prod = 16'd0;
    #3;
    n_cmp++;
    if ({bus.fimOp, bus.ocupado, bus.estado, bus.resultado} !== 20'd0) begin
      n_err++;
      $display("FAIL reset: got fimOp %b ocupado %b estado %0d res %0d expected all 0",
               bus.fimOp, bus.ocupado, bus.estado, bus.resultado);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.estado !== 2'd0 || bus.ocupado !== 1'b0) begin
      n_err++;
      $display("FAIL idle: got estado %0d ocupado %b expected 0 0", bus.estado, bus.ocupado);
    end
  endtask

  task automatic test_basic();
    run_op(8'd13, 8'd11, 2, "basic");
  endtask

  task automatic test_extremes();
    run_op(8'd255, 8'd255, 1, "max");
    run_op(8'd0, 8'd200, 0, "zero");
    run_op(8'd1, 8'd255, 0, "one");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_abort();
    bus.dadoA = 8'd7;
    bus.dadoB = 8'd9;
    bus.HabOp = 1'b1;
    repeat (3) @(negedge clk);
    bus.HabOp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.estado !== 2'd0 || bus.fimOp !== 1'b0 || bus.resultado !== last_prod) begin
        n_err++;
        $display("FAIL abort %0d: got estado %0d fimOp %b res %0d expected 0 0 %0d",
                 i, bus.estado, bus.fimOp, bus.resultado, last_prod);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.dadoA = 8'd100;
    bus.dadoB = 8'd3;
    bus.HabOp = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.fimOp, bus.ocupado, bus.estado, bus.resultado} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_mid: got fimOp %b ocupado %b estado %0d res %0d expected all 0",
               bus.fimOp, bus.ocupado, bus.estado, bus.resultado);
    end
    last_prod = 16'd0;
    bus.HabOp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(8'd100, 8'd3, 0, "restart");
  endtask

  task automatic test_back_to_back();
    run_op(8'd12, 8'd12, 0, "b2b_first");
    run_op(8'd5, 8'd6, 1, "b2b_second");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
